// File: rtl/sram_rr_ctrl.sv
// Two-requester round-robin arbiter and sequencer for a single-port SRAM
// with a registered (1-cycle latency) read port. Each requester issues one
// read or write at a time and receives a single-cycle ack on completion.
module sram_rr_ctrl #(
  parameter int addr = 3,
  parameter int data = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_a,
  input  logic            we_a,
  input  logic [addr-1:0] addr_a,
  input  logic [data-1:0] wdata_a,
  output logic            ack_a,
  output logic            gnt_a,
  input  logic            req_b,
  input  logic            we_b,
  input  logic [addr-1:0] addr_b,
  input  logic [data-1:0] wdata_b,
  output logic            ack_b,
  output logic            gnt_b,
  output logic [data-1:0] rdata,
  output logic            busy,
  output logic            mem_wr,
  output logic [addr-1:0] mem_addr,
  output logic [data-1:0] mem_din,
  input  logic [data-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, RCAP, RESP} state_t;

  state_t          state_q, state_d;
  logic            prio_q, prio_d;     // 0: A wins contention, 1: B wins
  logic            owner_q, owner_d;   // 0: A owns the transaction, 1: B
  logic            cmd_we_q, cmd_we_d;
  logic [addr-1:0] cmd_addr_q, cmd_addr_d;
  logic [data-1:0] cmd_din_q, cmd_din_d;
  logic [data-1:0] rdata_q, rdata_d;
  logic            win_b;

  // B wins when it is the only requester, or when both request and B holds priority.
  assign win_b = req_b & (~req_a | prio_q);

  // Next-state logic: arbitrate and latch the command in IDLE, sequence the SRAM access after.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    owner_d    = owner_q;
    cmd_we_d   = cmd_we_q;
    cmd_addr_d = cmd_addr_q;
    cmd_din_d  = cmd_din_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          owner_d    = win_b;
          cmd_we_d   = win_b ? we_b    : we_a;
          cmd_addr_d = win_b ? addr_b  : addr_a;
          cmd_din_d  = win_b ? wdata_b : wdata_a;
          state_d    = ISSUE;
        end
      end
      ISSUE: state_d = cmd_we_q ? RESP : RCAP;
      RCAP: begin
        rdata_d = mem_dout;
        state_d = RESP;
      end
      RESP: begin
        prio_d  = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and command registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      owner_q    <= 1'b0;
      cmd_we_q   <= 1'b0;
      cmd_addr_q <= '0;
      cmd_din_q  <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      owner_q    <= owner_d;
      cmd_we_q   <= cmd_we_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_din_q  <= cmd_din_d;
      rdata_q    <= rdata_d;
    end
  end

  // The command registers only change when leaving IDLE, so driving the SRAM
  // bus straight from them holds the last address/data between transactions.
  // The write strobe is gated by rst so an abandoned write never lands.
  assign mem_addr = cmd_addr_q;
  assign mem_din  = cmd_din_q;
  assign mem_wr   = (state_q == ISSUE) & cmd_we_q & rst;

  assign busy  = (state_q != IDLE);
  assign gnt_a = busy & ~owner_q;
  assign gnt_b = busy & owner_q;
  assign ack_a = (state_q == RESP) & ~owner_q;
  assign ack_b = (state_q == RESP) & owner_q;
  assign rdata = rdata_q;

endmodule
